traffic_intersection: RTL and testbench

TRAFFIC_INTERSECTION -- requirements
Module: traffic_intersection

---
 rtl/traffic_pkg.sv | 46 ++++
 rtl/phase_timer.sv | 32 +++
 rtl/traffic_intersection.sv | 156 +++++++++++++++
 tb/tb_traffic_intersection.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic intersection controller: FSM states,
// per-direction light codes ({R,G,Y}) and small elaboration-time helpers.
package traffic_pkg;

   typedef enum logic [2:0] {
      ST_GREEN   = 3'd0,
      ST_YELLOW  = 3'd1,
      ST_ALL_RED = 3'd2,
      ST_WALK    = 3'd3,
      ST_FLASH   = 3'd4
   } state_e;

   localparam logic [2:0] LIGHT_RED    = 3'b100;
   localparam logic [2:0] LIGHT_GREEN  = 3'b010;
   localparam logic [2:0] LIGHT_YELLOW = 3'b001;
   localparam logic [2:0] LIGHT_OFF    = 3'b000;

   // Light code of one direction, given the state, whether that direction is
   // the one being served, and the current flash half-period.
   function automatic logic [2:0] light_code(input state_e st, input logic is_active,
                                             input logic flash_on);
      logic [2:0] code;
      case (st)
         ST_GREEN:  code = is_active ? LIGHT_GREEN  : LIGHT_RED;
         ST_YELLOW: code = is_active ? LIGHT_YELLOW : LIGHT_RED;
         ST_FLASH:  code = flash_on  ? LIGHT_YELLOW : LIGHT_OFF;
         default:   code = LIGHT_RED;
      endcase
      return code;
   endfunction

   // Counter width: enough bits to hold (largest duration - 1), never below 1.
   function automatic int timer_width(input int a, input int b, input int c,
                                      input int d, input int e);
      int m;
      int w;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times one phase. done_o is high while the count
// is zero; the count parks at zero until the next load.
module phase_timer #(
   parameter int             W       = 3,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         done_o
);

   logic [W-1:0] count_q;

   // Load on phase entry, otherwise count down towards zero while enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= RST_VAL;
      end else if (en_i) begin
         if (load_i) begin
            count_q <= load_val_i;
         end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   assign done_o = (count_q == '0);

endmodule

// File: rtl/traffic_intersection.sv
// Multi-direction traffic light controller with pedestrian phase and a
// flashing-yellow override. All outputs come straight from registers.
module traffic_intersection
   import traffic_pkg::*;
#(
   parameter int NUM_DIR    = 2,
   parameter int GREEN_CYC  = 8,
   parameter int YELLOW_CYC = 3,
   parameter int ALLRED_CYC = 2,
   parameter int WALK_CYC   = 6,
   parameter int FLASH_CYC  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 ped_req,
   input  logic                 flash_mode,
   output logic [3*NUM_DIR-1:0] light,
   output logic                 walk,
   output logic [1:0]           active_dir
);

   localparam int CW = timer_width(GREEN_CYC, YELLOW_CYC, ALLRED_CYC, WALK_CYC, FLASH_CYC);

   localparam logic [CW-1:0] GREEN_LD  = CW'(GREEN_CYC - 1);
   localparam logic [CW-1:0] YELLOW_LD = CW'(YELLOW_CYC - 1);
   localparam logic [CW-1:0] ALLRED_LD = CW'(ALLRED_CYC - 1);
   localparam logic [CW-1:0] WALK_LD   = CW'(WALK_CYC - 1);
   localparam logic [CW-1:0] FLASH_LD  = CW'(FLASH_CYC - 1);
   localparam logic [1:0]    LAST_DIR  = 2'(NUM_DIR - 1);

   state_e               state_q, state_d;
   logic [1:0]           dir_q, dir_d;
   logic                 pend_q, pend_d;
   logic                 flash_on_q, flash_on_d;
   logic [3*NUM_DIR-1:0] light_q, light_d;
   logic                 walk_q, walk_d;

   logic                 tmr_load;
   logic [CW-1:0]        tmr_val;
   logic                 tmr_done;
   logic [1:0]           next_dir;

   phase_timer #(
      .W       (CW),
      .RST_VAL (ALLRED_LD)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   assign next_dir = (dir_q == LAST_DIR) ? 2'd0 : dir_q + 2'd1;

   // Next-state logic: flash override first, then timed phase sequencing.
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      pend_d     = pend_q;
      flash_on_d = flash_on_q;
      tmr_load   = 1'b0;
      tmr_val    = '0;

      if (en) begin
         // Requests are latched everywhere except WALK (ignored) and FLASH (held).
         if (ped_req && state_q != ST_WALK && state_q != ST_FLASH) begin
            pend_d = 1'b1;
         end

         if (flash_mode) begin
            if (state_q != ST_FLASH) begin
               state_d    = ST_FLASH;
               flash_on_d = 1'b1;
               tmr_load   = 1'b1;
               tmr_val    = FLASH_LD;
            end else if (tmr_done) begin
               flash_on_d = ~flash_on_q;
               tmr_load   = 1'b1;
               tmr_val    = FLASH_LD;
            end
         end else if (state_q == ST_FLASH) begin
            // Park on the last direction so the following GREEN serves direction 0.
            state_d  = ST_ALL_RED;
            dir_d    = LAST_DIR;
            tmr_load = 1'b1;
            tmr_val  = ALLRED_LD;
         end else if (tmr_done) begin
            tmr_load = 1'b1;
            case (state_q)
               ST_GREEN: begin
                  state_d = ST_YELLOW;
                  tmr_val = YELLOW_LD;
               end
               ST_YELLOW: begin
                  state_d = ST_ALL_RED;
                  tmr_val = ALLRED_LD;
               end
               ST_ALL_RED: begin
                  if (pend_q) begin
                     state_d = ST_WALK;
                     pend_d  = 1'b0;
                     tmr_val = WALK_LD;
                  end else begin
                     state_d = ST_GREEN;
                     dir_d   = next_dir;
                     tmr_val = GREEN_LD;
                  end
               end
               ST_WALK: begin
                  state_d = ST_GREEN;
                  dir_d   = next_dir;
                  tmr_val = GREEN_LD;
               end
               default: begin
                  state_d = ST_ALL_RED;
                  tmr_val = ALLRED_LD;
               end
            endcase
         end
      end
   end

   // Per-direction decode of the next state into light codes.
   for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_dir
      assign light_d[3*gi +: 3] = light_code(state_d, dir_d == 2'(gi), flash_on_d);
   end

   assign walk_d = (state_d == ST_WALK);

   // FSM and output registers; with en low every _d equals its _q, so all hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_ALL_RED;
         dir_q      <= LAST_DIR;
         pend_q     <= 1'b0;
         flash_on_q <= 1'b0;
         light_q    <= {NUM_DIR{LIGHT_RED}};
         walk_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         pend_q     <= pend_d;
         flash_on_q <= flash_on_d;
         light_q    <= light_d;
         walk_q     <= walk_d;
      end
   end

   assign light      = light_q;
   assign walk       = walk_q;
   assign active_dir = dir_q;

endmodule

// File: tb/tb_traffic_intersection.sv
// Directed bench for traffic_intersection: a 2-direction instance for the
// main scenarios and a 4-direction instance for green rotation order.
module tb_traffic_intersection;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, ped_req, flash_mode;
   logic [5:0]  light;
   logic        walk;
   logic [1:0]  active_dir;

   logic        rst4, en4, ped4, flash4;
   logic [11:0] light4;
   logic        walk4;
   logic [1:0]  dir4;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [5:0]  RR = 6'b100_100;
   localparam logic [5:0]  G0 = 6'b100_010;
   localparam logic [5:0]  Y0 = 6'b100_001;
   localparam logic [5:0]  G1 = 6'b010_100;
   localparam logic [5:0]  Y1 = 6'b001_100;
   localparam logic [5:0]  FY = 6'b001_001;
   localparam logic [5:0]  FO = 6'b000_000;
   localparam logic [11:0] RR4 = 12'b100_100_100_100;

   traffic_intersection #(
      .NUM_DIR(2), .GREEN_CYC(4), .YELLOW_CYC(2), .ALLRED_CYC(1), .WALK_CYC(3), .FLASH_CYC(2)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .ped_req(ped_req), .flash_mode(flash_mode),
      .light(light), .walk(walk), .active_dir(active_dir)
   );

   traffic_intersection #(
      .NUM_DIR(4), .GREEN_CYC(4), .YELLOW_CYC(2), .ALLRED_CYC(1), .WALK_CYC(3), .FLASH_CYC(2)
   ) dut4 (
      .clk(clk), .rst(rst4), .en(en4), .ped_req(ped4), .flash_mode(flash4),
      .light(light4), .walk(walk4), .active_dir(dir4)
   );

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // n clocks of the 2-direction instance, checked after each rising edge.
   task automatic expect_n(input string tag, input int n, input logic [5:0] exp_light,
                           input logic exp_walk, input int exp_dir);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk({tag, "_light"}, {6'b0, light}, {6'b0, exp_light});
         chk({tag, "_walk"}, {11'b0, walk}, {11'b0, exp_walk});
         if (exp_dir >= 0) chk({tag, "_dir"}, {10'b0, active_dir}, 12'(exp_dir));
      end
   endtask

   function automatic logic [11:0] mk4(input int d, input logic [2:0] code);
      logic [11:0] v;
      v = RR4;
      v[3*d +: 3] = code;
      return v;
   endfunction

   task automatic expect4(input string tag, input int n, input logic [11:0] exp_light,
                          input int exp_dir);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk({tag, "_light"}, light4, exp_light);
         chk({tag, "_dir"}, {10'b0, dir4}, 12'(exp_dir));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b1; ped_req = 1'b0; flash_mode = 1'b0;
      rst4 = 1'b1; en4 = 1'b1; ped4 = 1'b0; flash4 = 1'b0;

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      chk("rst_light", {6'b0, light}, {6'b0, RR});
      chk("rst_walk", {11'b0, walk}, 12'd0);
      chk("rst_dir", {10'b0, active_dir}, 12'd1);
      chk("rst4_light", light4, RR4);
      chk("rst4_dir", {10'b0, dir4}, 12'd3);

      // Basic sequencing.
      rst = 1'b0;
      expect_n("basic_g0", 4, G0, 1'b0, 0);
      expect_n("basic_y0", 2, Y0, 1'b0, 0);
      expect_n("basic_ar0", 1, RR, 1'b0, 0);
      expect_n("basic_g1", 4, G1, 1'b0, 1);
      expect_n("basic_y1", 2, Y1, 1'b0, 1);
      expect_n("basic_ar1", 1, RR, 1'b0, 1);
      expect_n("basic_wrap_g0", 1, G0, 1'b0, 0);

      // Pedestrian request during dir0 green; repeat request during WALK ignored.
      ped_req = 1'b1;
      expect_n("ped_g0", 1, G0, 1'b0, 0);
      ped_req = 1'b0;
      expect_n("ped_g0b", 2, G0, 1'b0, 0);
      expect_n("ped_y0", 2, Y0, 1'b0, 0);
      expect_n("ped_ar", 1, RR, 1'b0, 0);
      expect_n("ped_walk1", 1, RR, 1'b1, 0);
      ped_req = 1'b1;
      expect_n("ped_walk2", 1, RR, 1'b1, 0);
      ped_req = 1'b0;
      expect_n("ped_walk3", 1, RR, 1'b1, 0);
      expect_n("ped_g1", 4, G1, 1'b0, 1);
      expect_n("ped_y1", 2, Y1, 1'b0, 1);
      expect_n("ped_ar1", 1, RR, 1'b0, 1);
      expect_n("ped_no_rewalk", 1, G0, 1'b0, 0);

      // Flash mode mid-green.
      flash_mode = 1'b1;
      expect_n("flash_on1", 2, FY, 1'b0, -1);
      expect_n("flash_off", 2, FO, 1'b0, -1);
      expect_n("flash_on2", 2, FY, 1'b0, -1);
      flash_mode = 1'b0;
      expect_n("flash_exit_ar", 1, RR, 1'b0, -1);
      expect_n("flash_exit_g0", 4, G0, 1'b0, 0);

      // Enable freeze on the first yellow clock; requests while frozen are dropped.
      expect_n("frz_y0_first", 1, Y0, 1'b0, 0);
      en = 1'b0;
      ped_req = 1'b1;
      expect_n("frz_hold", 5, Y0, 1'b0, 0);
      ped_req = 1'b0;
      en = 1'b1;
      expect_n("frz_y0_last", 1, Y0, 1'b0, 0);
      expect_n("frz_ar", 1, RR, 1'b0, 0);
      expect_n("frz_g1", 2, G1, 1'b0, 1);

      // Mid-green asynchronous reset with a pending request.
      ped_req = 1'b1;
      expect_n("mrst_g1", 1, G1, 1'b0, 1);
      ped_req = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("mrst_async_light", {6'b0, light}, {6'b0, RR});
      chk("mrst_async_walk", {11'b0, walk}, 12'd0);
      chk("mrst_async_dir", {10'b0, active_dir}, 12'd1);
      @(negedge clk);
      chk("mrst_held_light", {6'b0, light}, {6'b0, RR});
      rst = 1'b0;
      expect_n("mrst_g0", 4, G0, 1'b0, 0);
      expect_n("mrst_y0", 2, Y0, 1'b0, 0);
      expect_n("mrst_ar", 1, RR, 1'b0, 0);
      expect_n("mrst_pend_cleared", 1, G1, 1'b0, 1);

      // Four directions: green order 0,1,2,3,0.
      rst4 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         expect4("dir4_green", 4, mk4(k % 4, 3'b010), k % 4);
         expect4("dir4_yellow", 2, mk4(k % 4, 3'b001), k % 4);
         expect4("dir4_allred", 1, RR4, k % 4);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
